// File: rtl/pi_loop_sched.sv
// pi_loop_sched: time-multiplexed incremental-PI scheduler.
// One shared error/multiply/accumulate datapath serves NCH motor channels
// once per control tick. All channel duties are published together.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   run          loop enable; low clears all channel state
//   set_bus      NCH x 32-bit signed setpoints (channel c at [32c+31:32c])
//   fb_bus       NCH x 32-bit signed feedback, same packing
//   kp_ki, kp    shared gains A = Kp+Ki and B = Kp
//   out_bus      NCH x 16-bit signed saturated duties
//   out_valid    one-cycle strobe, out_bus updated in the same cycle
//   busy         high while a sweep is in progress
//   overrun      sticky: a tick arrived while a sweep was in progress
//
// Optional feature: define PI_SCHED_ANTIWINDUP_EN to clamp each channel's
// accumulator to +/-OUT_MAX after every update.
module pi_loop_sched #(
    parameter int unsigned NCH      = 5,
    parameter int unsigned PERIOD   = 50000,
    parameter int unsigned DEADBAND = 32,
    parameter int unsigned SHIFT    = 8,
    parameter int unsigned OUT_MAX  = 3000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [NCH*32-1:0]   set_bus,
    input  logic [NCH*32-1:0]   fb_bus,
    input  logic [31:0]         kp_ki,
    input  logic [31:0]         kp,
    output logic [NCH*16-1:0]   out_bus,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic signed [31:0] LIM_P = 32'(OUT_MAX);
    localparam logic signed [31:0] LIM_N = -LIM_P;
    localparam logic signed [31:0] DB_P  = 32'(DEADBAND);
    localparam logic signed [31:0] DB_N  = -DB_P;

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_MULP, S_MULI, S_ACC, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic               tick_c;
    logic [CH_W-1:0]    ch;
    logic               last_c;

    logic signed [31:0] set_s [NCH];
    logic signed [31:0] fb_s  [NCH];
    logic signed [31:0] gain_a, gain_b;
    logic signed [31:0] e_q, p_q, i_q;
    logic signed [31:0] acc      [NCH];
    logic signed [31:0] prev_err [NCH];
    logic signed [15:0] staged   [NCH];

    logic signed [31:0] e_raw_c, e_c, delta_c, sum_c, acc_c;
    logic signed [15:0] duty_c;

    function automatic logic signed [31:0] clamp(input logic signed [31:0] v);
        if (v > LIM_P)      clamp = LIM_P;
        else if (v < LIM_N) clamp = LIM_N;
        else                clamp = v;
    endfunction

    // Free-running control-period counter, held at 0 while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (!run || tick_c)    cnt <= '0;
        else                        cnt <= cnt + CNT_W'(1);
    end

    assign tick_c = run && (cnt == CNT_W'(PERIOD - 1));
    assign last_c = (ch == CH_W'(NCH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: four cycles per channel, then one publish cycle
    always_comb begin
        state_nxt = state;
        if (!run) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (tick_c) state_nxt = S_ERR;
                S_ERR:   state_nxt = S_MULP;
                S_MULP:  state_nxt = S_MULI;
                S_MULI:  state_nxt = S_ACC;
                S_ACC:   state_nxt = last_c ? S_DONE : S_ERR;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Error with deadband, and the accumulate/brake/saturate step
    always_comb begin
        e_raw_c = (set_s[ch] <<< 7) - fb_s[ch];
        e_c     = ((e_raw_c > DB_N) && (e_raw_c < DB_P)) ? '0 : e_raw_c;
        delta_c = (p_q - i_q) >>> SHIFT;
        sum_c   = acc[ch] + delta_c;
        if (set_s[ch] == '0) begin
            acc_c = '0;
        end else begin
`ifdef PI_SCHED_ANTIWINDUP_EN
            acc_c = clamp(sum_c);
`else
            acc_c = sum_c;
`endif
        end
        duty_c = 16'(clamp(acc_c));
    end

    // Datapath, per-channel state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch        <= '0;
            gain_a    <= '0;
            gain_b    <= '0;
            e_q       <= '0;
            p_q       <= '0;
            i_q       <= '0;
            out_bus   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int c = 0; c < int'(NCH); c++) begin
                set_s[c]    <= '0;
                fb_s[c]     <= '0;
                acc[c]      <= '0;
                prev_err[c] <= '0;
                staged[c]   <= '0;
            end
        end else if (!run) begin
            ch        <= '0;
            out_bus   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int c = 0; c < int'(NCH); c++) begin
                acc[c]      <= '0;
                prev_err[c] <= '0;
                staged[c]   <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            busy      <= (state_nxt != S_IDLE);
            if (tick_c && (state != S_IDLE)) overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (tick_c) begin
                        ch     <= '0;
                        gain_a <= kp_ki;
                        gain_b <= kp;
                        for (int c = 0; c < int'(NCH); c++) begin
                            set_s[c] <= set_bus[32*c +: 32];
                            fb_s[c]  <= fb_bus[32*c +: 32];
                        end
                    end
                end
                S_ERR:  e_q <= e_c;
                S_MULP: p_q <= gain_a * e_q;
                S_MULI: i_q <= gain_b * prev_err[ch];
                S_ACC: begin
                    acc[ch]      <= acc_c;
                    prev_err[ch] <= e_q;
                    staged[ch]   <= duty_c;
                    if (last_c) begin
                        // Publish in the DONE cycle, with this channel's fresh duty
                        out_valid <= 1'b1;
                        for (int c = 0; c < int'(NCH); c++) begin
                            out_bus[16*c +: 16] <= (CH_W'(c) == ch) ? duty_c : staged[c];
                        end
                    end else begin
                        ch <= ch + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pi_loop_sched.sv
// Testbench for pi_loop_sched: scoreboard of expected duty vectors produced
// by a plain-arithmetic reference model, checked by an independent monitor.
module tb_pi_loop_sched;

    localparam int NCH         = 5;
    localparam int PERIOD      = 16;
    localparam int DEADBAND    = 32;
    localparam int SHIFT       = 8;
    localparam int OUT_MAX     = 3000;
    localparam int FIRST_BUSY  = PERIOD;                    // cycles after run rises
    localparam int FIRST_VALID = PERIOD + 4*NCH;
    localparam int SPACING     = ((4*NCH + 1) / PERIOD + 1) * PERIOD;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                run = 1'b0;
    logic [NCH*32-1:0]   set_bus = '0;
    logic [NCH*32-1:0]   fb_bus = '0;
    logic [31:0]         kp_ki = '0;
    logic [31:0]         kp = '0;
    logic [NCH*16-1:0]   out_bus;
    logic                out_valid;
    logic                busy;
    logic                overrun;

    pi_loop_sched #(
        .NCH(NCH), .PERIOD(PERIOD), .DEADBAND(DEADBAND),
        .SHIFT(SHIFT), .OUT_MAX(OUT_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .set_bus(set_bus), .fb_bus(fb_bus), .kp_ki(kp_ki), .kp(kp),
        .out_bus(out_bus), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [NCH*16-1:0] exp_q[$];
    int set_v[NCH];
    int fb_v[NCH];
    int m_acc[NCH];
    int m_prev[NCH];
    int rc;
    logic busy_d = 1'b0;
    int valid_seen = 0;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [NCH*16-1:0] act,
                             input logic [NCH*16-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v > OUT_MAX)  return OUT_MAX;
        if (v < -OUT_MAX) return -OUT_MAX;
        return v;
    endfunction

    // Cycles elapsed since run was (re)enabled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rc <= 0;
        else if (!run) rc <= 0;
        else           rc <= rc + 1;
    end

    // Monitor: pops the scoreboard on every published result
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && !busy_d) begin
                check_int("busy_rise_phase",
                          int'(rc >= FIRST_BUSY && (rc - FIRST_BUSY) % SPACING == 0), 1);
                check_int("overrun_at_sweep_start", int'(overrun),
                          int'(rc >= FIRST_BUSY + PERIOD));
            end
            if (out_valid) begin
                valid_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: out_bus=%h with nothing expected at %0t",
                             out_bus, $time);
                end else begin
                    check_vec("duties", out_bus, exp_q.pop_front());
                end
                check_int("valid_latency",
                          int'(rc >= FIRST_VALID && (rc - FIRST_VALID) % SPACING == 0), 1);
                check_int("busy_during_valid", int'(busy), 1);
                check_int("overrun_sticky", int'(overrun), 1);
            end
        end
        busy_d = busy;
    end

    task automatic apply();
        for (int c = 0; c < NCH; c++) begin
            set_bus[32*c +: 32] = 32'(set_v[c]);
            fb_bus[32*c +: 32]  = 32'(fb_v[c]);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_acc[c]  = 0;
            m_prev[c] = 0;
        end
    endtask

    // One sweep of the incremental PI law on the currently applied inputs
    task automatic push_sweep();
        logic [NCH*16-1:0] v;
        int e, p, i, d, a, b;
        a = int'(kp_ki);
        b = int'(kp);
        v = '0;
        for (int c = 0; c < NCH; c++) begin
            e = set_v[c] * 128 - fb_v[c];
            if (e > -DEADBAND && e < DEADBAND) e = 0;
            p = a * e;
            i = b * m_prev[c];
            d = (p - i) >>> SHIFT;
            if (set_v[c] == 0) begin
                m_acc[c] = 0;
            end else begin
                m_acc[c] = m_acc[c] + d;
`ifdef PI_SCHED_ANTIWINDUP_EN
                m_acc[c] = sat(m_acc[c]);
`endif
            end
            m_prev[c] = e;
            v[16*c +: 16] = 16'(sat(m_acc[c]));
        end
        exp_q.push_back(v);
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_valid_timeout: no out_valid within 200 cycles at %0t", $time);
    endtask

    task automatic wait_busy_rise();
        int n;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        while (!busy && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_busy_timeout: busy never rose at %0t", $time);
        end
    endtask

    task automatic sweep();
        apply();
        push_sweep();
        wait_valid();
    endtask

    task automatic new_group(input int s0, input int f0);
        run = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            set_v[c] = 0;
            fb_v[c]  = 0;
        end
        set_v[0] = s0;
        fb_v[0]  = f0;
        kp_ki = 32'd360;
        kp    = 32'd210;
        apply();
        run = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_vec("reset_out_bus", out_bus, '0);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        // Basic step: 180 then 255
        new_group(1, 0);
        sweep();
        sweep();

        // Deadband: zero error, then confirm prev_err stayed 0
        new_group(1, 100);
        repeat (3) sweep();
        fb_v[0] = 0;
        sweep();

        // Saturation and windup behaviour
        new_group(100, 0);
        sweep();
        fb_v[0] = 12800;
        sweep();

        // Brake and restart
        new_group(1, 0);
        sweep();
        sweep();
        set_v[0] = 0;
        sweep();
        set_v[0] = 1;
        sweep();
        sweep();

        // Randomized sweeps across all channels
        new_group(0, 0);
        for (int k = 0; k < 20; k++) begin
            kp_ki = 32'($urandom_range(0, 1000));
            kp    = 32'($urandom_range(0, 800));
            for (int c = 0; c < NCH; c++) begin
                set_v[c] = int'($urandom_range(0, 60)) - 30;
                if ($urandom_range(0, 3) == 0)
                    fb_v[c] = set_v[c] * 128 + int'($urandom_range(0, 60)) - 30;
                else
                    fb_v[c] = set_v[c] * 128 + int'($urandom_range(0, 8000)) - 4000;
            end
            sweep();
        end

        // run drop mid-sweep
        new_group(5, 0);
        sweep();
        wait_busy_rise();
        repeat (6) @(negedge clk);
        run = 1'b0;
        model_reset();
        @(negedge clk);
        check_int("rundrop_busy", int'(busy), 0);
        check_vec("rundrop_out_bus", out_bus, '0);
        check_int("rundrop_overrun", int'(overrun), 0);
        valid_seen = 0;
        repeat (40) @(negedge clk);
        check_int("rundrop_no_valid", valid_seen, 0);

        // Asynchronous reset mid-sweep
        new_group(5, 0);
        sweep();
        wait_busy_rise();
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_vec("rst_out_bus", out_bus, '0);
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_overrun", int'(overrun), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sweep();

        run = 1'b0;
        repeat (5) @(negedge clk);
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
